alu_issue_stage: RTL

- Producer side of the ALU operand/control interface. Decodes ALUOp/funct7/funct3 from the decode stage into the 3-bit ALU control encoding.
- Selects the second operand and registers both operands and the control code into the ID/EX boundary that feeds the ALU.
- Sequences multi-cycle multiplies: it holds the issued op and back-pressures decode until the multiply result is ready.

---
 rtl/alu_issue_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/funct7/funct3 into the 3-bit ALU control code,
// registers the operands at the ID/EX boundary and holds multi-cycle multiplies.
module alu_issue_stage #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [6:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic        ALUSrc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic        flush_i,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  output logic [2:0]  ALUCtrl_o,
  output logic        valid_o,
  output logic        illegal_o,
  output logic        stall_o
);

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_MUL = 3'b010;
  localparam logic [2:0] CTRL_AND = 3'b011;
  localparam logic [2:0] CTRL_OR  = 3'b100;

  localparam logic [3:0] BUSY_LOAD = 4'(MUL_LAT - 1);
  localparam logic       MULTI_CYCLE_MUL = (MUL_LAT > 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [2:0]  dec_ctrl;
  logic        dec_illegal;
  logic [31:0] operand2;
  logic        load_bubble;
  logic        start_mul;

  // Unsupported encodings still issue as an add, only flagged as illegal.
  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b0;
    case (ALUOp_i)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b10: begin
        case ({funct7_i, funct3_i})
          {7'b0000000, 3'b000}: dec_ctrl = CTRL_ADD;
          {7'b0000000, 3'b111}: dec_ctrl = CTRL_AND;
          {7'b0000000, 3'b110}: dec_ctrl = CTRL_OR;
          {7'b0100000, 3'b000}: dec_ctrl = CTRL_SUB;
          {7'b0000001, 3'b000}: dec_ctrl = CTRL_MUL;
          default:              dec_illegal = 1'b1;
        endcase
      end
      default: begin
        case (funct3_i)
          3'b000:  dec_ctrl = CTRL_ADD;
          3'b111:  dec_ctrl = CTRL_AND;
          3'b110:  dec_ctrl = CTRL_OR;
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign operand2    = ALUSrc_i ? imm_i : rs2_data_i;
  assign load_bubble = flush_i || !valid_i;
  assign start_mul   = valid_i && !flush_i && (dec_ctrl == CTRL_MUL) && MULTI_CYCLE_MUL;
  assign stall_o     = (state == MUL_BUSY);

  // The exit edge from MUL_BUSY does not capture, so a mul holds for MUL_LAT cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      count     <= '0;
      data1_o   <= '0;
      data2_o   <= '0;
      ALUCtrl_o <= CTRL_ADD;
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_bubble) begin
            data1_o   <= '0;
            data2_o   <= '0;
            ALUCtrl_o <= CTRL_ADD;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
          end else begin
            data1_o   <= rs1_data_i;
            data2_o   <= operand2;
            ALUCtrl_o <= dec_ctrl;
            valid_o   <= 1'b1;
            illegal_o <= dec_illegal;
          end
          if (start_mul) begin
            state <= MUL_BUSY;
            count <= BUSY_LOAD;
          end
        end
        MUL_BUSY: begin
          if (flush_i) begin
            data1_o   <= '0;
            data2_o   <= '0;
            ALUCtrl_o <= CTRL_ADD;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            state     <= IDLE;
            count     <= '0;
          end else if (count == 4'd1) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule
